// File: rtl/hack_uart_pkg.sv
// hack_uart_pkg: shared state encoding and default word width for the UART transmit path
package hack_uart_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT_DONE = 2'd2} state_t;
   localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector
//   req   : pending requests
//   last  : index granted most recently; scanning starts just above it
//   grant : one-hot winner, idx : its index, any : some request is pending
module rr_pick #(
   parameter int NREQ = 2,
   parameter int LW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [LW-1:0]   last,
   output logic [NREQ-1:0] grant,
   output logic [LW-1:0]   idx,
   output logic            any
);
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = |req;
      // Scan from farthest to nearest so the nearest set bit above last wins.
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(last) + k) % NREQ]) begin
            idx   = LW'((int'(last) + k) % NREQ);
            grant = NREQ'(1) << ((int'(last) + k) % NREQ);
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UartTX among NREQ requesters with round-robin selection
//   CLK_100MHz, RESET_N (async, active-low)
//   REQ/DATA  : per-requester pending flag and flattened data words
//   GRANT     : one-cycle one-hot pulse when a word is captured
//   TX_LOAD/TX_DATA/TX_BUSY : UartTX handshake
//   ACTIVE    : not idle, TIMEOUT : one-cycle pulse when TX_BUSY never rose
module uart_tx_arbiter
   import hack_uart_pkg::*;
#(
   parameter int NREQ         = 2,
   parameter int WIDTH        = DEF_WIDTH,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                  CLK_100MHz,
   input  logic                  RESET_N,
   input  logic [NREQ-1:0]       REQ,
   input  logic [NREQ*WIDTH-1:0] DATA,
   output logic [NREQ-1:0]       GRANT,
   output logic                  TX_LOAD,
   output logic [WIDTH-1:0]      TX_DATA,
   input  logic                  TX_BUSY,
   output logic                  ACTIVE,
   output logic                  TIMEOUT
);
   localparam int LW = $clog2(NREQ);
   localparam int CW = $clog2(BUSY_TIMEOUT) + 1;
   state_t state, state_n;
   logic [LW-1:0] last, last_n, pick_idx;
   logic [CW-1:0] cnt, cnt_n;
   logic [NREQ-1:0] grant_n, pick_grant;
   logic [WIDTH-1:0] data_n;
   logic load_n, tmo_n, pick_any;
   rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
      .req   (REQ),
      .last  (last),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );
   always_comb begin
      state_n = state;
      last_n  = last;
      cnt_n   = cnt;
      grant_n = '0;
      data_n  = TX_DATA;
      load_n  = TX_LOAD;
      tmo_n   = 1'b0;
      case (state)
         IDLE: if (!TX_BUSY && pick_any) begin
            state_n = LOAD;
            last_n  = pick_idx;
            grant_n = pick_grant;
            data_n  = DATA[int'(pick_idx)*WIDTH +: WIDTH];
            load_n  = 1'b1;
            cnt_n   = '0;
         end
         LOAD: if (TX_BUSY) begin
            load_n  = 1'b0;
            state_n = WAIT_DONE;
         end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
            // UartTX never acknowledged: drop the word rather than retry.
            load_n  = 1'b0;
            tmo_n   = 1'b1;
            state_n = IDLE;
         end else begin
            cnt_n = cnt + 1'b1;
         end
         WAIT_DONE: state_n = TX_BUSY ? WAIT_DONE : IDLE;
         default: begin
            state_n = IDLE;
            load_n  = 1'b0;
         end
      endcase
   end
   always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         last    <= LW'(NREQ - 1);
         cnt     <= '0;
         GRANT   <= '0;
         TX_LOAD <= 1'b0;
         TX_DATA <= '0;
         ACTIVE  <= 1'b0;
         TIMEOUT <= 1'b0;
      end else begin
         state   <= state_n;
         last    <= last_n;
         cnt     <= cnt_n;
         GRANT   <= grant_n;
         TX_LOAD <= load_n;
         TX_DATA <= data_n;
         ACTIVE  <= state_n != IDLE;
         TIMEOUT <= tmo_n;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] req = '0;
   logic [31:0] data = {16'h0031, 16'h0030};
   logic tx_busy = 1'b0;
   logic [1:0] grant;
   logic tx_load, active, tmo;
   logic [15:0] tx_data;
   int errors = 0;
   int checks = 0;
   int n;
   always #5 clk = ~clk;
   uart_tx_arbiter #(.NREQ(2), .WIDTH(16), .BUSY_TIMEOUT(16)) dut (
      .CLK_100MHz (clk),
      .RESET_N    (rst_n),
      .REQ        (req),
      .DATA       (data),
      .GRANT      (grant),
      .TX_LOAD    (tx_load),
      .TX_DATA    (tx_data),
      .TX_BUSY    (tx_busy),
      .ACTIVE     (active),
      .TIMEOUT    (tmo)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic xfer(input string tag, input logic [1:0] eg, input logic [15:0] ed);
      step();
      chk({tag, "_grant"}, 32'(grant), 32'(eg));
      chk({tag, "_data"}, 32'(tx_data), 32'(ed));
      tx_busy = 1'b1;
      step();
      step();
      tx_busy = 1'b0;
      step();
   endtask
   initial begin
      step();
      step();
      chk("rst_outs", {grant, tx_load, tx_data, active, tmo}, 32'h0);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         n += int'(active);
      end
      chk("idle_active", 32'(n), 0);
      data = {16'h0031, 16'h0041};
      req = 2'b01;
      step();
      chk("single_grant", 32'(grant), 32'h1);
      chk("single_data", 32'(tx_data), 32'h41);
      chk("single_load1", 32'(tx_load), 32'h1);
      req = 2'b00;
      step();
      chk("single_grant_pulse", 32'(grant), 32'h0);
      chk("single_load2", 32'(tx_load), 32'h1);
      tx_busy = 1'b1;
      step();
      chk("single_load_fall", 32'(tx_load), 32'h0);
      for (int i = 0; i < 99; i++) step();
      chk("single_active_busy", 32'(active), 32'h1);
      tx_busy = 1'b0;
      step();
      chk("single_active_end", 32'(active), 32'h0);
      chk("single_data_hold", 32'(tx_data), 32'h41);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      data = {16'h0031, 16'h0030};
      req = 2'b11;
      xfer("rr0", 2'b01, 16'h0030);
      xfer("rr1", 2'b10, 16'h0031);
      xfer("rr2", 2'b01, 16'h0030);
      xfer("rr3", 2'b10, 16'h0031);
      req = 2'b10;
      tx_busy = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         n += int'(grant != 2'b00);
      end
      chk("busy_gate", 32'(n), 0);
      tx_busy = 1'b0;
      step();
      chk("busy_release_grant", 32'(grant), 32'h2);
      req = 2'b00;
      tx_busy = 1'b1;
      step();
      step();
      tx_busy = 1'b0;
      step();
      req = 2'b01;
      step();
      chk("tmo_grant", 32'(grant), 32'h1);
      req = 2'b00;
      n = 0;
      for (int i = 0; i < 40 && tx_load; i++) begin
         n++;
         chk("tmo_early", 32'(tmo), 32'h0);
         step();
      end
      chk("tmo_load_width", 32'(n), 32'd16);
      chk("tmo_pulse", 32'(tmo), 32'h1);
      chk("tmo_idle", 32'(active), 32'h0);
      step();
      chk("tmo_pulse_end", 32'(tmo), 32'h0);
      req = 2'b10;
      step();
      chk("tmo_next_grant", 32'(grant), 32'h2);
      req = 2'b00;
      tx_busy = 1'b1;
      step();
      step();
      chk("mid_wait_active", 32'(active), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_load", 32'(tx_load), 32'h0);
      chk("mid_rst_active", 32'(active), 32'h0);
      chk("mid_rst_data", 32'(tx_data), 32'h0);
      tx_busy = 1'b0;
      step();
      rst_n = 1'b1;
      req = 2'b11;
      step();
      chk("post_rst_grant", 32'(grant), 32'h1);
      chk("post_rst_data", 32'(tx_data), 32'h30);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UartTX transmitter among NREQ requesters, e.g. the echo path and the CPU's MemoryMappedIO port. Each requester presents a word with a request/grant handshake. The arbiter picks requesters round-robin, captures the chosen word, and drives UartTX LOAD/IN. It sequences the LOAD pulse against TX_BUSY, so callers never touch TX_BUSY themselves. It sits between the requesters and the UartTX instance at top level.

## Interface
- NREQ, 2: number of requesters, 2..8.
- WIDTH, 16: data word width. It matches UartTX IN.
- BUSY_TIMEOUT, 16: maximum number of cycles in LOAD waiting for TX_BUSY to rise.
- CLK_100MHz  in  1  system clock; everything is on the rising edge.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- REQ  in  NREQ  REQ[i] high means requester i has a word pending.
- DATA  in  NREQ*WIDTH  flattened data; requester i uses bits [i*WIDTH +: WIDTH].
- GRANT  out  NREQ  one-hot, one-cycle pulse: the word of requester i has been captured.
- TX_LOAD  out  1  to UartTX LOAD.
- TX_DATA  out  WIDTH  to UartTX IN; registered.
- TX_BUSY  in  1  from UartTX TX_BUSY.
- ACTIVE  out  1  high whenever the state is not IDLE.
- TIMEOUT  out  1  one-cycle pulse when BUSY_TIMEOUT expires.

## Operation
- Reset values: state IDLE, GRANT=0, TX_LOAD=0, TX_DATA=0, TIMEOUT=0, ACTIVE=0, last-grant pointer=NREQ-1, timeout counter=0.
- IDLE, when TX_BUSY=0 and REQ!=0:
  - select the first set REQ bit scanning upward from (last+1) mod NREQ, wrapping;
  - set TX_DATA to that requester's DATA slice;
  - pulse GRANT[i];
  - set last=i;
  - set TX_LOAD=1, clear the counter, go to LOAD.
- IDLE, otherwise (TX_BUSY=1 or REQ=0): stay. Nothing is granted while TX_BUSY=1.
- LOAD: TX_LOAD is held at 1 and the counter increments each cycle. Exit on the first of:
  - TX_BUSY=1: TX_LOAD=0, go to WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT-1 with TX_BUSY still 0: TX_LOAD=0, pulse TIMEOUT, go to IDLE. The word is dropped; it is not re-queued.
- WAIT_DONE: stay while TX_BUSY=1; go to IDLE when TX_BUSY=0.
- REQ is ignored outside IDLE.
- Requester contract: hold REQ and DATA stable until GRANT is seen; drop REQ (or present the next word) in the cycle after GRANT.
  - A requester may drop REQ before it is granted (withdrawal) with no side effects.
  - A REQ still high after GRANT is treated as a new word.
- Fairness: with all REQ high continuously, grants rotate 0,1,…,NREQ-1,0,…
- A single requester with REQ held high is granted on every IDLE visit.
- Reset asserted mid-transfer: all outputs return to reset values immediately. The UartTX frame already in flight is not aborted.
- TX_DATA keeps its last value after the transfer completes.

## Timing
- REQ sampled at edge k in IDLE: GRANT, TX_LOAD and TX_DATA are valid after edge k, for the cycle k..k+1. Latency is 1 cycle.
- GRANT is high for exactly 1 cycle.
- TX_LOAD stays high from that cycle until the cycle in which TX_BUSY is sampled high; its minimum width is 1 cycle.
- TX_BUSY sampled low at edge m in WAIT_DONE: state is IDLE after edge m, and the next GRANT comes after edge m+1 at the earliest.
- Timeout: with TX_BUSY stuck at 0, TX_LOAD is high for exactly BUSY_TIMEOUT cycles, and TIMEOUT pulses on the cycle TX_LOAD falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- The shared package (hack_uart_pkg) holds:
  - the state encoding: IDLE=2'd0, LOAD=2'd1, WAIT_DONE=2'd2;
  - the default WIDTH=16.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: REQ[NREQ], last[$clog2(NREQ)].
  - Outputs: one-hot grant, index, any.
  - It is reused for any future shared-resource arbiter.
- The top module holds the FSM, the timeout counter, and the TX_DATA/last registers.

## Test plan
- Reset: with RESET_N low, all outputs are 0. Releasing reset with REQ=0 keeps ACTIVE=0 for 20 cycles.
- Single request, NREQ=2:
  - Stimulus: REQ=2'b01, DATA[15:0]=16'h0041; model UartTX raising TX_BUSY 2 cycles after LOAD, busy for 100 cycles.
  - Required: GRANT=2'b01 for 1 cycle, TX_DATA=16'h0041, TX_LOAD high for 2 cycles, ACTIVE high until 1 cycle after TX_BUSY falls.
- Round-robin:
  - Stimulus: REQ=2'b11 held; DATA0=16'h0030, DATA1=16'h0031.
  - Required: transmitted sequence 0x30, 0x31, 0x30, 0x31; GRANT alternates.
- Busy gating: TX_BUSY held high externally with REQ=2'b10 → no GRANT. TX_BUSY falls → GRANT=2'b10 after the next edge.
- Timeout: TX_BUSY stuck at 0, REQ=2'b01, BUSY_TIMEOUT=16 → TX_LOAD high for exactly 16 cycles, TIMEOUT pulse for 1 cycle, return to IDLE, new GRANT on the next sampled REQ.
- Mid-transfer reset: assert RESET_N low while in WAIT_DONE → TX_LOAD=0, ACTIVE=0 immediately. After release, the pointer restarts and the first grant goes to requester 0.
